// File: rtl/gray_sweep_gen.sv
// gray_sweep_gen
//   Registered Gray-code sweep source. A start pulse loads start_bin and
//   begins stepping a binary count toward end_bin, one step per enabled
//   cycle, up or down with modulo-2^WIDTH wrap. Every count is presented
//   both as binary (bin_q) and as its Gray encoding (gray_out) on the same
//   edge, so a downstream Gray-to-binary stage can be checked against bin_q.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      single-cycle sweep request, honoured only while idle
//   stop       abort a running sweep (ignored while idle)
//   en         step enable while running; low holds the count
//   up_dn      direction, 1 = increment, 0 = decrement (sampled with start)
//   start_bin  first binary value of the sweep (sampled with start)
//   end_bin    final binary value of the sweep (sampled with start)
//   gray_out   registered Gray code of bin_q
//   bin_q      registered binary count
//   busy       high while a sweep is running
//   done       one-cycle pulse when the count lands on the end value
//   wrap       one-cycle pulse on a step that crosses the wrap boundary
//
// Handshake: start is a one-cycle request with no ready; it is accepted on
// any edge where the block is idle and dropped otherwise. stop and en are
// level controls evaluated on every edge while running, stop winning.
module gray_sweep_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] start_bin,
  input  logic [WIDTH-1:0] end_bin,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_n;
  logic             dir, dir_n;
  logic [WIDTH-1:0] end_q, end_n;
  logic [WIDTH-1:0] bin_n;
  logic [WIDTH-1:0] step;
  logic             done_n, wrap_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin_q    <= '0;
      gray_out <= '0;
      dir      <= 1'b0;
      end_q    <= '0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_n;
      bin_q    <= bin_n;
      // Encoded from the next binary value so both outputs move together.
      gray_out <= bin_n ^ (bin_n >> 1);
      dir      <= dir_n;
      end_q    <= end_n;
      done     <= done_n;
      wrap     <= wrap_n;
    end
  end

  always_comb begin
    state_n = state;
    bin_n   = bin_q;
    dir_n   = dir;
    end_n   = end_q;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    step    = dir ? (bin_q + ONE) : (bin_q - ONE);

    case (state)
      IDLE: begin
        if (start) begin
          bin_n = start_bin;
          if (start_bin == end_bin) begin
            // Zero-length sweep: present the value and finish at once.
            done_n = 1'b1;
          end else begin
            state_n = RUN;
            dir_n   = up_dn;
            end_n   = end_bin;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (en) begin
          bin_n  = step;
          // Crossing happens when leaving all-ones going up or zero going down.
          wrap_n = dir ? (&bin_q) : ~(|bin_q);
          if (step == end_q) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Derived from the state register only, so no input reaches it directly.
  assign busy = (state == RUN);

endmodule

// File: tb/tb_gray_sweep_gen.sv
module tb_gray_sweep_gen;
  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         en;
  logic         up_dn;
  logic [W-1:0] start_bin;
  logic [W-1:0] end_bin;
  logic [W-1:0] gray_out;
  logic [W-1:0] bin_q;
  logic         busy;
  logic         done;
  logic         wrap;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];

  gray_sweep_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .en        (en),
    .up_dn     (up_dn),
    .start_bin (start_bin),
    .end_bin   (end_bin),
    .gray_out  (gray_out),
    .bin_q     (bin_q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0;
    stop  = 1'b0;
    en    = 1'b0;
  endtask

  task automatic begin_sweep(input int s, input int e, input logic d, input logic step_en);
    start     = 1'b1;
    start_bin = W'(s);
    end_bin   = W'(e);
    up_dn     = d;
    en        = step_en;
    stop      = 1'b0;
    tick();
    start     = 1'b0;
    // Scramble sampled-with-start inputs; they must not affect the sweep.
    start_bin = W'($urandom_range(0, MOD - 1));
    end_bin   = W'($urandom_range(0, MOD - 1));
    up_dn     = 1'($urandom_range(0, 1));
  endtask

  // ---------------- reference helpers ----------------
  // Gray code from its definition: each bit is the XOR of neighbouring binary bits.
  function automatic logic [W-1:0] gray_of(input int b);
    logic [W-1:0] g;
    for (int i = 0; i < W; i++)
      g[i] = ((b >> i) & 1) != ((b >> (i + 1)) & 1);
    return g;
  endfunction

  function automatic string show(input logic [W-1:0] g, input logic [W-1:0] b,
                                 input logic bs, input logic d, input logic w);
    return $sformatf("gray=%0d bin=%0d busy=%b done=%b wrap=%b", g, b, bs, d, w);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'($urandom_range(0, 1));
    stop      = 1'($urandom_range(0, 1));
    en        = 1'($urandom_range(0, 1));
    up_dn     = 1'($urandom_range(0, 1));
    start_bin = W'($urandom_range(1, MOD - 1));
    end_bin   = W'($urandom_range(0, MOD - 1));
    tick();
    tick();
    checks++;
    if ({gray_out, bin_q, busy, done, wrap} !== '0) begin
      errors++;
      $display("FAIL reset: got %s, expected all zero", show(gray_out, bin_q, busy, done, wrap));
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_up_sweep();
    int           exp_g[4]  = '{3, 2, 6, 7};
    int           exp_b[4]  = '{2, 3, 4, 5};
    logic         exp_bs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic         exp_d[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    begin_sweep(2, 5, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if ({gray_out, bin_q, busy, done, wrap} !== {W'(exp_g[i]), W'(exp_b[i]), exp_bs[i], exp_d[i], 1'b0}) begin
        errors++;
        $display("FAIL up_sweep[%0d]: got %s, expected %s", i, show(gray_out, bin_q, busy, done, wrap),
                 show(W'(exp_g[i]), W'(exp_b[i]), exp_bs[i], exp_d[i], 1'b0));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_down_wrap();
    int   exp_g[4]  = '{1, 0, 8, 9};
    int   exp_b[4]  = '{1, 0, 15, 14};
    logic exp_bs[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_d[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic exp_w[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    begin_sweep(1, 14, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if ({gray_out, bin_q, busy, done, wrap} !== {W'(exp_g[i]), W'(exp_b[i]), exp_bs[i], exp_d[i], exp_w[i]}) begin
        errors++;
        $display("FAIL down_wrap[%0d]: got %s, expected %s", i, show(gray_out, bin_q, busy, done, wrap),
                 show(W'(exp_g[i]), W'(exp_b[i]), exp_bs[i], exp_d[i], exp_w[i]));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_pause_abort();
    logic en_seq[11]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic stop_seq[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int   exp_b[11]    = '{1, 2, 3, 3, 3, 3, 4, 5, 5, 5, 5};
    logic exp_bs[11]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    begin_sweep(0, 9, 1'b1, 1'b1);
    checks++;
    if ({bin_q, busy} !== {W'(0), 1'b1}) begin
      errors++;
      $display("FAIL pause_start: got bin=%0d busy=%b, expected bin=0 busy=1", bin_q, busy);
    end
    for (int i = 0; i < 11; i++) begin
      en   = en_seq[i];
      stop = stop_seq[i];
      tick();
      checks++;
      if ({gray_out, bin_q, busy, done, wrap} !== {gray_of(exp_b[i]), W'(exp_b[i]), exp_bs[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL pause_abort[%0d]: got %s, expected %s", i, show(gray_out, bin_q, busy, done, wrap),
                 show(gray_of(exp_b[i]), W'(exp_b[i]), exp_bs[i], 1'b0, 1'b0));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_degenerate();
    begin_sweep(6, 6, 1'b1, 1'b1);
    checks++;
    if ({gray_out, bin_q, busy, done, wrap} !== {W'(5), W'(6), 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL degenerate: got %s, expected %s", show(gray_out, bin_q, busy, done, wrap),
               show(W'(5), W'(6), 1'b0, 1'b1, 1'b0));
    end
    tick();
    checks++;
    if ({gray_out, bin_q, busy, done, wrap} !== {W'(5), W'(6), 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL degenerate_after: got %s, expected %s", show(gray_out, bin_q, busy, done, wrap),
               show(W'(5), W'(6), 1'b0, 1'b0, 1'b0));
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    begin_sweep(0, 12, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bin_q !== W'(7) || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre: got bin=%0d busy=%b, expected bin=7 busy=1", bin_q, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({gray_out, bin_q, busy, done, wrap} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %s, expected all zero", show(gray_out, bin_q, busy, done, wrap));
    end
    begin_sweep(3, 4, 1'b1, 1'b1);
    checks++;
    if ({gray_out, bin_q, busy, done, wrap} !== {gray_of(3), W'(3), 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restart_first: got %s, expected %s", show(gray_out, bin_q, busy, done, wrap),
               show(gray_of(3), W'(3), 1'b1, 1'b0, 1'b0));
    end
    tick();
    checks++;
    if ({gray_out, bin_q, busy, done, wrap} !== {gray_of(4), W'(4), 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL restart_done: got %s, expected %s", show(gray_out, bin_q, busy, done, wrap),
               show(gray_of(4), W'(4), 1'b0, 1'b1, 1'b0));
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_full_wrap();
    begin_sweep(0, MOD - 1, 1'b0, 1'b1);
    tick();
    checks++;
    if ({gray_out, bin_q, busy, done, wrap} !== {W'(8), W'(15), 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL full_wrap: got %s, expected %s", show(gray_out, bin_q, busy, done, wrap),
               show(W'(8), W'(15), 1'b0, 1'b1, 1'b1));
    end
    idle_inputs();
    tick();
  endtask

  // Random sweeps: the expected path is precomputed as a queue of counts.
  task automatic test_random();
    int           s, e, cur, budget;
    logic         d, active, ebs, ed, ew;
    logic [W-1:0] nb, prev_g;
    for (int n = 0; n < 25; n++) begin
      s = $urandom_range(0, MOD - 1);
      e = (n % 5 == 0) ? s : $urandom_range(0, MOD - 1);
      d = 1'($urandom_range(0, 1));
      begin_sweep(s, e, d, 1'b0);
      checks++;
      if ({gray_out, bin_q, busy, done, wrap} !== {gray_of(s), W'(s), 1'(s != e), 1'(s == e), 1'b0}) begin
        errors++;
        $display("FAIL rand_start[%0d]: got %s, expected %s", n, show(gray_out, bin_q, busy, done, wrap),
                 show(gray_of(s), W'(s), 1'(s != e), 1'(s == e), 1'b0));
      end
      exp_q.delete();
      cur = s;
      while (cur != e) begin
        cur = d ? (cur + 1) % MOD : (cur + MOD - 1) % MOD;
        exp_q.push_back(W'(cur));
      end
      cur    = s;
      active = (s != e);
      budget = 0;
      while (active && budget < 300) begin
        en        = ($urandom_range(0, 3) != 0);
        stop      = ($urandom_range(0, 39) == 0);
        start     = 1'($urandom_range(0, 1));
        up_dn     = 1'($urandom_range(0, 1));
        start_bin = W'($urandom_range(0, MOD - 1));
        end_bin   = W'($urandom_range(0, MOD - 1));
        prev_g    = gray_of(cur);
        tick();
        budget++;
        ebs = 1'b1;
        ed  = 1'b0;
        ew  = 1'b0;
        if (stop) begin
          ebs    = 1'b0;
          active = 1'b0;
        end else if (en) begin
          nb  = exp_q.pop_front();
          ew  = d ? (cur == MOD - 1) : (cur == 0);
          ed  = (exp_q.size() == 0);
          ebs = !ed;
          cur = nb;
          if (ed) active = 1'b0;
          checks++;
          if ($countones(gray_out ^ prev_g) != 1) begin
            errors++;
            $display("FAIL rand_one_bit[%0d]: got gray %0d after %0d, required a one-bit change",
                     n, gray_out, prev_g);
          end
        end
        checks++;
        if ({gray_out, bin_q, busy, done, wrap} !== {gray_of(cur), W'(cur), ebs, ed, ew}) begin
          errors++;
          $display("FAIL rand_step[%0d.%0d]: got %s, expected %s", n, budget,
                   show(gray_out, bin_q, busy, done, wrap), show(gray_of(cur), W'(cur), ebs, ed, ew));
        end
      end
      if (active) begin
        checks++;
        errors++;
        $display("FAIL rand_timeout[%0d]: got sweep still running after %0d cycles, required done", n, budget);
      end
      idle_inputs();
    end
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    en        = 1'b0;
    up_dn     = 1'b0;
    start_bin = '0;
    end_bin   = '0;
    test_reset();
    test_up_sweep();
    test_down_wrap();
    test_pause_abort();
    test_degenerate();
    test_reset_mid();
    test_full_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
